ub_access_ctrl: RTL and testbench

// - Parametrised unified-buffer storage plus access controller for the UB/systolic subsystem.
// - Owns DEPTH x BUFFER_WIDTH storage with two streaming read ports (input and weight), one CU random-access port and a PPU drain writer.
// - CU requests are granted on a ready/ack basis. A drain sequencer steps ppu_cycle_idx and writes PPU rows back to the buffer.

---
 rtl/ub_access_ctrl_if.sv | 65 ++++++
 rtl/ub_access_ctrl.sv | 141 ++++++++++++++
 tb/tb_ub_access_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ub_access_ctrl_if.sv
// Bus bundle for ub_access_ctrl: CU random-access port, two streaming read ports and the PPU drain port.
// The master modport is the requester side and the slave modport is the buffer controller.
interface ub_access_ctrl_if #(
   parameter int ARRAY_SIZE = 4,
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 16
);
   localparam int BUFFER_WIDTH = ARRAY_SIZE * DATA_WIDTH;
   localparam int IDX_WIDTH    = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;

   logic                    cu_req;
   logic                    cu_wr_en;
   logic [ADDR_WIDTH-1:0]   cu_addr;
   logic [BUFFER_WIDTH-1:0] cu_wdata;
   logic                    cu_ack;
   logic [BUFFER_WIDTH-1:0] cu_rdata;
   logic                    cu_rvalid;

   logic                    in_valid;
   logic [ADDR_WIDTH-1:0]   in_addr;
   logic                    in_first;
   logic                    in_last;
   logic [BUFFER_WIDTH-1:0] in_data;
   logic                    in_first_o;
   logic                    in_last_o;

   logic                    wt_valid;
   logic [ADDR_WIDTH-1:0]   wt_addr;
   logic                    wt_first;
   logic                    wt_last;
   logic [BUFFER_WIDTH-1:0] wt_data;
   logic                    wt_first_o;
   logic                    wt_last_o;

   logic                    drain_start;
   logic [ADDR_WIDTH-1:0]   drain_base;
   logic [BUFFER_WIDTH-1:0] ppu_wdata;
   logic                    ppu_capture_en;
   logic [IDX_WIDTH-1:0]    ppu_cycle_idx;
   logic                    drain_busy;
   logic                    drain_done;
   logic                    addr_err;

   modport master (
      output cu_req, cu_wr_en, cu_addr, cu_wdata,
      input  cu_ack, cu_rdata, cu_rvalid,
      output in_valid, in_addr, in_first, in_last,
      input  in_data, in_first_o, in_last_o,
      output wt_valid, wt_addr, wt_first, wt_last,
      input  wt_data, wt_first_o, wt_last_o,
      output drain_start, drain_base, ppu_wdata,
      input  ppu_capture_en, ppu_cycle_idx, drain_busy, drain_done, addr_err
   );

   modport slave (
      input  cu_req, cu_wr_en, cu_addr, cu_wdata,
      output cu_ack, cu_rdata, cu_rvalid,
      input  in_valid, in_addr, in_first, in_last,
      output in_data, in_first_o, in_last_o,
      input  wt_valid, wt_addr, wt_first, wt_last,
      output wt_data, wt_first_o, wt_last_o,
      input  drain_start, drain_base, ppu_wdata,
      output ppu_capture_en, ppu_cycle_idx, drain_busy, drain_done, addr_err
   );
endinterface

// File: rtl/ub_access_ctrl.sv
// Unified buffer storage with CU access, input/weight stream reads and a PPU drain sequencer.
// Optional macro UB_FWD_EN: same-cycle writes forward into reads (read-new instead of read-old).
module ub_access_ctrl #(
   parameter int ARRAY_SIZE   = 4,
   parameter int DATA_WIDTH   = 16,
   parameter int BUFFER_WIDTH = ARRAY_SIZE * DATA_WIDTH,
   parameter int DEPTH        = 256,
   parameter int ADDR_WIDTH   = 16
) (
   input logic            clk,
   input logic            rst_n,
   ub_access_ctrl_if.slave bus
);
   localparam int IDX_WIDTH = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
   localparam int MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0]  DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(ARRAY_SIZE - 1);

   typedef enum logic [1:0] {IDLE, CAPTURE, WRITE, DONE} state_t;

   state_t                  state, state_next;
   logic [IDX_WIDTH-1:0]    idx, idx_next;
   logic [ADDR_WIDTH-1:0]   base, base_next;
   logic [BUFFER_WIDTH-1:0] mem [DEPTH];

   logic                    drain_wr, cu_ack, cu_wr, cu_rd, wr_en, err_now;
   logic [ADDR_WIDTH-1:0]   drain_addr, wr_addr;
   logic [BUFFER_WIDTH-1:0] wr_data;
   logic [BUFFER_WIDTH-1:0] cu_rdata, in_data, wt_data;
   logic                    cu_rvalid, in_first_o, in_last_o, wt_first_o, wt_last_o, addr_err;

   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
      return {1'b0, a} < DEPTH_LIM;
   endfunction

   function automatic logic [BUFFER_WIDTH-1:0] read_word(input logic [ADDR_WIDTH-1:0] a);
      logic [BUFFER_WIDTH-1:0] r;
      r = '0;
      if (in_range(a)) r = mem[a[MEM_AW-1:0]];
`ifdef UB_FWD_EN
      if (in_range(a) && wr_en && (wr_addr == a)) r = wr_data;
`endif
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         idx   <= '0;
         base  <= '0;
      end else begin
         state <= state_next;
         idx   <= idx_next;
         base  <= base_next;
      end
   end

   // Drain base is latched at start so the PPU rows land contiguously even if drain_base moves.
   always_comb begin
      state_next = state;
      idx_next   = idx;
      base_next  = base;
      case (state)
         IDLE: begin
            if (bus.drain_start) begin
               state_next = CAPTURE;
               base_next  = bus.drain_base;
               idx_next   = '0;
            end
         end
         CAPTURE: state_next = WRITE;
         WRITE: begin
            if (idx == LAST_IDX) begin
               state_next = DONE;
               idx_next   = '0;
            end else begin
               idx_next = idx + 1'b1;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign drain_wr   = (state == WRITE);
   assign drain_addr = base + ADDR_WIDTH'(idx);
   assign cu_ack     = bus.cu_req & ~(bus.cu_wr_en & drain_wr);
   assign cu_wr      = cu_ack & bus.cu_wr_en;
   assign cu_rd      = cu_ack & ~bus.cu_wr_en;
   assign wr_en      = drain_wr | cu_wr;
   assign wr_addr    = drain_wr ? drain_addr : bus.cu_addr;
   assign wr_data    = drain_wr ? bus.ppu_wdata : bus.cu_wdata;
   assign err_now    = (cu_ack & ~in_range(bus.cu_addr))
                     | (bus.in_valid & ~in_range(bus.in_addr))
                     | (bus.wt_valid & ~in_range(bus.wt_addr))
                     | (drain_wr & ~in_range(drain_addr));

   // Storage has no reset; writes are suppressed while reset is held.
   always_ff @(posedge clk) begin
      if (rst_n && wr_en && in_range(wr_addr)) mem[wr_addr[MEM_AW-1:0]] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cu_rdata   <= '0;
         cu_rvalid  <= 1'b0;
         in_data    <= '0;
         wt_data    <= '0;
         in_first_o <= 1'b0;
         in_last_o  <= 1'b0;
         wt_first_o <= 1'b0;
         wt_last_o  <= 1'b0;
         addr_err   <= 1'b0;
      end else begin
         cu_rvalid  <= cu_rd;
         if (cu_rd) cu_rdata <= read_word(bus.cu_addr);
         if (bus.in_valid) in_data <= read_word(bus.in_addr);
         if (bus.wt_valid) wt_data <= read_word(bus.wt_addr);
         in_first_o <= bus.in_valid & bus.in_first;
         in_last_o  <= bus.in_valid & bus.in_last;
         wt_first_o <= bus.wt_valid & bus.wt_first;
         wt_last_o  <= bus.wt_valid & bus.wt_last;
         if (err_now) addr_err <= 1'b1;
      end
   end

   assign bus.cu_ack         = cu_ack;
   assign bus.cu_rdata       = cu_rdata;
   assign bus.cu_rvalid      = cu_rvalid;
   assign bus.in_data        = in_data;
   assign bus.in_first_o     = in_first_o;
   assign bus.in_last_o      = in_last_o;
   assign bus.wt_data        = wt_data;
   assign bus.wt_first_o     = wt_first_o;
   assign bus.wt_last_o      = wt_last_o;
   assign bus.ppu_capture_en = (state == CAPTURE);
   assign bus.ppu_cycle_idx  = idx;
   assign bus.drain_busy     = (state != IDLE);
   assign bus.drain_done     = (state == DONE);
   assign bus.addr_err       = addr_err;
endmodule

// File: tb/tb_ub_access_ctrl.sv
// Scoreboard bench for ub_access_ctrl: expected words are queued when reads are issued and popped when data appears.
// A model array tracks every write the bench performs.
module tb_ub_access_ctrl;
   localparam int ARRAY_SIZE = 4;
   localparam int DATA_WIDTH = 16;
   localparam int DEPTH      = 256;
   localparam int ADDR_WIDTH = 16;
   localparam int BW         = ARRAY_SIZE * DATA_WIDTH;

   typedef logic [BW-1:0] word_t;
   typedef struct {
      word_t data;
      logic  first;
      logic  last;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ub_access_ctrl_if #(.ARRAY_SIZE(ARRAY_SIZE), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

   ub_access_ctrl #(
      .ARRAY_SIZE(ARRAY_SIZE),
      .DATA_WIDTH(DATA_WIDTH),
      .BUFFER_WIDTH(BW),
      .DEPTH(DEPTH),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   word_t model_mem [DEPTH];
   word_t cu_q [$];
   beat_t in_q [$];
   beat_t wt_q [$];
   int    passed = 0;
   int    total  = 0;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.cu_req      = 1'b0;
      bus.cu_wr_en    = 1'b0;
      bus.cu_addr     = '0;
      bus.cu_wdata    = '0;
      bus.in_valid    = 1'b0;
      bus.in_addr     = '0;
      bus.in_first    = 1'b0;
      bus.in_last     = 1'b0;
      bus.wt_valid    = 1'b0;
      bus.wt_addr     = '0;
      bus.wt_first    = 1'b0;
      bus.wt_last     = 1'b0;
      bus.drain_start = 1'b0;
      bus.drain_base  = '0;
      bus.ppu_wdata   = '0;
   endtask

   task automatic cu_drive(input logic wr, input logic [ADDR_WIDTH-1:0] a, input word_t d);
      bus.cu_req   = 1'b1;
      bus.cu_wr_en = wr;
      bus.cu_addr  = a;
      bus.cu_wdata = d;
   endtask

   task automatic cu_prewrite(input logic [ADDR_WIDTH-1:0] a, input word_t d);
      cu_drive(1'b1, a, d);
      tick();
      bus.cu_req = 1'b0;
      model_mem[a[7:0]] = d;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      tick();
      tick();
      total++;
      if (bus.cu_rvalid !== 1'b0 || bus.cu_rdata !== '0) $display("[TB] FAIL reset_cu: got rvalid=%b rdata=%h expected 0/0", bus.cu_rvalid, bus.cu_rdata);
      else passed++;
      total++;
      if (bus.in_data !== '0 || bus.wt_data !== '0) $display("[TB] FAIL reset_stream: got in=%h wt=%h expected 0", bus.in_data, bus.wt_data);
      else passed++;
      total++;
      if ({bus.in_first_o, bus.in_last_o, bus.wt_first_o, bus.wt_last_o} !== 4'b0) $display("[TB] FAIL reset_markers: got %b expected 0000", {bus.in_first_o, bus.in_last_o, bus.wt_first_o, bus.wt_last_o});
      else passed++;
      total++;
      if ({bus.ppu_capture_en, bus.drain_busy, bus.drain_done, bus.addr_err, bus.cu_ack, bus.ppu_cycle_idx} !== 7'b0) $display("[TB] FAIL reset_ctrl: got %b expected 0000000", {bus.ppu_capture_en, bus.drain_busy, bus.drain_done, bus.addr_err, bus.cu_ack, bus.ppu_cycle_idx});
      else passed++;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_cu_rw();
      word_t exp;
      cu_drive(1'b1, 16'd5, 64'h1111_2222_3333_4444);
      #1;
      total++;
      if (bus.cu_ack !== 1'b1) $display("[TB] FAIL t1_ack_wr: got %b expected 1", bus.cu_ack);
      else passed++;
      model_mem[5] = 64'h1111_2222_3333_4444;
      tick();
      total++;
      if (bus.cu_rvalid !== 1'b0) $display("[TB] FAIL t1_no_rvalid_on_wr: got %b expected 0", bus.cu_rvalid);
      else passed++;
      cu_drive(1'b0, 16'd5, '0);
      #1;
      total++;
      if (bus.cu_ack !== 1'b1) $display("[TB] FAIL t1_ack_rd: got %b expected 1", bus.cu_ack);
      else passed++;
      cu_q.push_back(model_mem[5]);
      tick();
      bus.cu_req = 1'b0;
      exp = cu_q.pop_front();
      total++;
      if (bus.cu_rvalid !== 1'b1 || bus.cu_rdata !== exp) $display("[TB] FAIL t1_rdata: got rvalid=%b data=%h expected 1/%h", bus.cu_rvalid, bus.cu_rdata, exp);
      else passed++;
      tick();
      total++;
      if (bus.cu_rvalid !== 1'b0 || bus.cu_rdata !== exp) $display("[TB] FAIL t1_hold: got rvalid=%b data=%h expected 0/%h", bus.cu_rvalid, bus.cu_rdata, exp);
      else passed++;
   endtask

   task automatic test_stream();
      beat_t b, w;
      for (int i = 0; i < 4; i++) cu_prewrite(16'(i), word_t'(64'hA5A5_0000_0000_0000) + word_t'(i * 64'h0001_0010_0100_1000));
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1;
         bus.in_addr  = 16'(i);
         bus.in_first = (i == 0);
         bus.in_last  = (i == 3);
         bus.wt_valid = 1'b1;
         bus.wt_addr  = 16'(3 - i);
         bus.wt_first = (i == 0);
         bus.wt_last  = (i == 3);
         b.data = model_mem[i];     b.first = (i == 0); b.last = (i == 3);
         w.data = model_mem[3 - i]; w.first = (i == 0); w.last = (i == 3);
         in_q.push_back(b);
         wt_q.push_back(w);
         tick();
         b = in_q.pop_front();
         w = wt_q.pop_front();
         total++;
         if (bus.in_data !== b.data || bus.in_first_o !== b.first || bus.in_last_o !== b.last)
            $display("[TB] FAIL t2_in_beat%0d: got %h f=%b l=%b expected %h f=%b l=%b", i, bus.in_data, bus.in_first_o, bus.in_last_o, b.data, b.first, b.last);
         else passed++;
         total++;
         if (bus.wt_data !== w.data || bus.wt_first_o !== w.first || bus.wt_last_o !== w.last)
            $display("[TB] FAIL t2_wt_beat%0d: got %h f=%b l=%b expected %h f=%b l=%b", i, bus.wt_data, bus.wt_first_o, bus.wt_last_o, w.data, w.first, w.last);
         else passed++;
      end
      bus.in_valid = 1'b0;
      bus.in_addr  = 16'd0;
      bus.in_first = 1'b1;
      bus.in_last  = 1'b1;
      bus.wt_valid = 1'b0;
      tick();
      total++;
      if (bus.in_data !== model_mem[3] || bus.in_first_o !== 1'b0 || bus.in_last_o !== 1'b0)
         $display("[TB] FAIL t2_gated_hold: got %h f=%b l=%b expected %h f=0 l=0", bus.in_data, bus.in_first_o, bus.in_last_o, model_mem[3]);
      else passed++;
      idle_inputs();
   endtask

   task automatic test_drain();
      word_t exp;
      int    cycles;
      bus.drain_base  = 16'h0040;
      bus.drain_start = 1'b1;
      cycles = 0;
      tick();
      cycles++;
      bus.drain_start = 1'b0;
      total++;
      if (bus.ppu_capture_en !== 1'b1 || bus.drain_busy !== 1'b1) $display("[TB] FAIL t3_capture: got cap=%b busy=%b expected 1/1", bus.ppu_capture_en, bus.drain_busy);
      else passed++;
      tick();
      cycles++;
      for (int k = 0; k < ARRAY_SIZE; k++) begin
         total++;
         if (bus.ppu_cycle_idx !== 2'(k) || bus.ppu_capture_en !== 1'b0 || bus.drain_done !== 1'b0)
            $display("[TB] FAIL t3_write_row%0d: got idx=%0d cap=%b done=%b expected %0d/0/0", k, bus.ppu_cycle_idx, bus.ppu_capture_en, bus.drain_done, k);
         else passed++;
         bus.ppu_wdata = word_t'(k * 16);
         model_mem[8'h40 + k] = word_t'(k * 16);
         tick();
         cycles++;
      end
      total++;
      if (bus.drain_done !== 1'b1 || cycles != 6) $display("[TB] FAIL t3_done: got done=%b at cycle %0d expected 1 at cycle 6", bus.drain_done, cycles);
      else passed++;
      tick();
      total++;
      if (bus.drain_done !== 1'b0 || bus.drain_busy !== 1'b0) $display("[TB] FAIL t3_idle: got done=%b busy=%b expected 0/0", bus.drain_done, bus.drain_busy);
      else passed++;
      for (int i = 0; i < ARRAY_SIZE; i++) begin
         cu_drive(1'b0, 16'h0040 + 16'(i), '0);
         cu_q.push_back(model_mem[8'h40 + i]);
         tick();
         exp = cu_q.pop_front();
         total++;
         if (bus.cu_rvalid !== 1'b1 || bus.cu_rdata !== exp) $display("[TB] FAIL t3_row%0d: got %h expected %h", i, bus.cu_rdata, exp);
         else passed++;
      end
      idle_inputs();
   endtask

   task automatic test_cu_during_drain();
      word_t exp;
      cu_prewrite(16'h0020, 64'hDEAD_BEEF_0000_0020);
      bus.drain_base  = 16'h0080;
      bus.drain_start = 1'b1;
      tick();
      bus.drain_start = 1'b0;
      tick();
      for (int k = 0; k < ARRAY_SIZE; k++) begin
         bus.ppu_wdata = word_t'(256 + k * 16);
         model_mem[8'h80 + k] = word_t'(256 + k * 16);
         if (k == 1) begin
            cu_drive(1'b0, 16'h0020, '0);
            #1;
            total++;
            if (bus.cu_ack !== 1'b1) $display("[TB] FAIL t4_read_ack: got %b expected 1", bus.cu_ack);
            else passed++;
            cu_q.push_back(model_mem[8'h20]);
         end else begin
            cu_drive(1'b1, 16'h0020, 64'h0BAD_F00D_0000_0020);
            bus.drain_start = (k == 2);
            #1;
            total++;
            if (bus.cu_ack !== 1'b0) $display("[TB] FAIL t4_wr_blocked_row%0d: got %b expected 0", k, bus.cu_ack);
            else passed++;
         end
         tick();
         if (k == 1) begin
            exp = cu_q.pop_front();
            total++;
            if (bus.cu_rvalid !== 1'b1 || bus.cu_rdata !== exp) $display("[TB] FAIL t4_read_data: got %h expected %h", bus.cu_rdata, exp);
            else passed++;
         end
      end
      bus.drain_start = 1'b0;
      #1;
      total++;
      if (bus.drain_done !== 1'b1 || bus.cu_ack !== 1'b1) $display("[TB] FAIL t4_done_ack: got done=%b ack=%b expected 1/1", bus.drain_done, bus.cu_ack);
      else passed++;
      model_mem[8'h20] = 64'h0BAD_F00D_0000_0020;
      tick();
      bus.cu_req = 1'b0;
      total++;
      if (bus.drain_busy !== 1'b0) $display("[TB] FAIL t4_start_ignored: got busy=%b expected 0", bus.drain_busy);
      else passed++;
      for (int i = 0; i < 2; i++) begin
         cu_drive(1'b0, (i == 0) ? 16'h0020 : 16'h0083, '0);
         cu_q.push_back((i == 0) ? model_mem[8'h20] : model_mem[8'h83]);
         tick();
         exp = cu_q.pop_front();
         total++;
         if (bus.cu_rdata !== exp) $display("[TB] FAIL t4_readback%0d: got %h expected %h", i, bus.cu_rdata, exp);
         else passed++;
      end
      idle_inputs();
   endtask

   task automatic test_same_addr();
      beat_t b;
      cu_prewrite(16'h0030, 64'h0000_0000_0000_0AAA);
      cu_drive(1'b1, 16'h0030, 64'h0000_0000_0000_0BBB);
      bus.in_valid = 1'b1;
      bus.in_addr  = 16'h0030;
`ifdef UB_FWD_EN
      b.data = 64'h0000_0000_0000_0BBB;
`else
      b.data = model_mem[8'h30];
`endif
      b.first = 1'b0;
      b.last  = 1'b0;
      in_q.push_back(b);
      model_mem[8'h30] = 64'h0000_0000_0000_0BBB;
      tick();
      bus.cu_req = 1'b0;
      b = in_q.pop_front();
      total++;
      if (bus.in_data !== b.data) $display("[TB] FAIL t5_collision: got %h expected %h", bus.in_data, b.data);
      else passed++;
      b.data = model_mem[8'h30];
      in_q.push_back(b);
      tick();
      b = in_q.pop_front();
      total++;
      if (bus.in_data !== b.data) $display("[TB] FAIL t5_after: got %h expected %h", bus.in_data, b.data);
      else passed++;
      idle_inputs();
   endtask

   task automatic test_addr_err_reset();
      word_t exp;
      logic  done_seen;
      total++;
      if (bus.addr_err !== 1'b0) $display("[TB] FAIL t6_err_clear: got %b expected 0", bus.addr_err);
      else passed++;
      cu_drive(1'b1, 16'(DEPTH), 64'hFFFF_FFFF_FFFF_FFFF);
      tick();
      total++;
      if (bus.addr_err !== 1'b1) $display("[TB] FAIL t6_err_set: got %b expected 1", bus.addr_err);
      else passed++;
      cu_drive(1'b0, 16'(DEPTH), '0);
      cu_q.push_back('0);
      tick();
      exp = cu_q.pop_front();
      total++;
      if (bus.cu_rvalid !== 1'b1 || bus.cu_rdata !== exp) $display("[TB] FAIL t6_oob_read: got %h expected %h", bus.cu_rdata, exp);
      else passed++;
      cu_drive(1'b0, 16'h0000, '0);
      cu_q.push_back(model_mem[0]);
      tick();
      bus.cu_req = 1'b0;
      exp = cu_q.pop_front();
      total++;
      if (bus.cu_rdata !== exp) $display("[TB] FAIL t6_no_alias: got %h expected %h", bus.cu_rdata, exp);
      else passed++;
      tick();
      tick();
      total++;
      if (bus.addr_err !== 1'b1) $display("[TB] FAIL t6_sticky: got %b expected 1", bus.addr_err);
      else passed++;
      bus.drain_base  = 16'h0050;
      bus.drain_start = 1'b1;
      tick();
      bus.drain_start = 1'b0;
      tick();
      bus.ppu_wdata = 64'h0000_0000_0000_5A5A;
      model_mem[8'h50] = 64'h0000_0000_0000_5A5A;
      tick();
      bus.ppu_wdata = 64'h0000_0000_0000_6B6B;
      rst_n = 1'b0;
      tick();
      total++;
      if ({bus.drain_busy, bus.drain_done, bus.addr_err, bus.ppu_cycle_idx} !== 5'b0)
         $display("[TB] FAIL t6_reset: got busy=%b done=%b err=%b idx=%0d expected 0/0/0/0", bus.drain_busy, bus.drain_done, bus.addr_err, bus.ppu_cycle_idx);
      else passed++;
      rst_n = 1'b1;
      done_seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus.drain_done === 1'b1 || bus.drain_busy === 1'b1) done_seen = 1'b1;
      end
      total++;
      if (done_seen !== 1'b0) $display("[TB] FAIL t6_no_done: got activity=%b expected 0", done_seen);
      else passed++;
      cu_drive(1'b0, 16'h0050, '0);
      cu_q.push_back(model_mem[8'h50]);
      tick();
      bus.cu_req = 1'b0;
      exp = cu_q.pop_front();
      total++;
      if (bus.cu_rdata !== exp) $display("[TB] FAIL t6_row_kept: got %h expected %h", bus.cu_rdata, exp);
      else passed++;
      idle_inputs();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      idle_inputs();
      test_reset();
      test_cu_rw();
      test_stream();
      test_drain();
      test_cu_during_drain();
      test_same_addr();
      test_addr_err_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
